// File: rtl/hazard_scoreboard.sv
// Hazard unit for the F/D/E/M/W pipeline: operand forwarding, load-use
// bubbles, memory-wait freeze and branch/PC-write flush control.
module hazard_scoreboard #(
  parameter int REG_W      = 4,
  parameter int LOAD_STALL = 1,
  parameter int PC_REG     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       HazState
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10
  } hazState_t;

  localparam logic [REG_W-1:0] PcIdx  = REG_W'(PC_REG);
  localparam logic [2:0]       LdInit = 3'(LOAD_STALL - 1);
  localparam bit               Multi  = (LOAD_STALL > 1);

  hazState_t  state;
  hazState_t  stateNext;
  logic [2:0] cnt;
  logic [2:0] cntNext;

  logic memStall;
  logic ldHit;
  logic pcPend;
  logic memHold;
  logic ldHold;

  function automatic logic [1:0] fwdSel(
    input logic             ra,
    input logic             dummy
  );
    fwdSel = {ra, dummy};
  endfunction

  function automatic logic [1:0] fwd(
    input logic [REG_W-1:0] ra,
    input logic             wm,
    input logic [REG_W-1:0] am,
    input logic             ww,
    input logic [REG_W-1:0] aw
  );
    if (wm && ra == am && am != PcIdx)
      fwd = fwdSel(1'b1, 1'b0);
    else if (ww && ra == aw && aw != PcIdx)
      fwd = fwdSel(1'b0, 1'b1);
    else
      fwd = 2'b00;
  endfunction

  assign memStall = MemReqM & ~MemReadyM;
  assign pcPend   = PCSrcD | PCSrcE | PCSrcM;
  assign ldHit    = MemtoRegE & RegWriteE & (WA3E != PcIdx)
                  & ((RA1D == WA3E) | (RA2D == WA3E));
  assign HazState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // cnt is left untouched across a memory wait so an interrupted
  // load stall resumes with the bubbles it still owes.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    memHold   = 1'b0;
    ldHold    = 1'b0;
    unique case (state)
      RUN: begin
        if (memStall) begin
          memHold   = 1'b1;
          stateNext = MEMWAIT;
        end else if (!BranchTakenE && ldHit) begin
          ldHold = 1'b1;
          if (Multi) begin
            stateNext = LDSTALL;
            cntNext   = LdInit;
          end
        end
      end
      LDSTALL: begin
        if (memStall) begin
          memHold   = 1'b1;
          stateNext = MEMWAIT;
        end else if (BranchTakenE) begin
          stateNext = RUN;
          cntNext   = 3'd0;
        end else begin
          ldHold  = 1'b1;
          cntNext = cnt - 3'd1;
          if (cnt <= 3'd1)
            stateNext = RUN;
        end
      end
      MEMWAIT: begin
        if (memStall) begin
          memHold = 1'b1;
        end else if (BranchTakenE) begin
          stateNext = RUN;
          cntNext   = 3'd0;
        end else begin
          stateNext = (cnt != 3'd0) ? LDSTALL : RUN;
        end
      end
      default: begin
        stateNext = RUN;
        cntNext   = 3'd0;
      end
    endcase
  end

  always_comb begin
    ForwardAE = fwd(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if (memHold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldHold | pcPend;
      StallD = ldHold;
      FlushE = ldHold | BranchTakenE;
      // a held D register must not also be bubbled
      FlushD = (pcPend | PCSrcW | BranchTakenE) & ~ldHold;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against a
// bubble-count reference model.
module tb_hazard_scoreboard;
  localparam int REG_W = 4;
  localparam int LS    = 3;
  localparam int PCR   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             RegWriteM, RegWriteW;
  logic [REG_W-1:0] WA3E, WA3M, WA3W;
  logic [REG_W-1:0] RA1E, RA2E, RA1D, RA2D;
  logic             MemtoRegE, RegWriteE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic             BranchTakenE, MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       HazState;

  hazard_scoreboard #(
    .REG_W(REG_W), .LOAD_STALL(LS), .PC_REG(PCR)
  ) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RA1E(RA1E), .RA2E(RA2E), .RA1D(RA1D), .RA2D(RA2D),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .HazState(HazState)
  );

  int nCmp = 0;
  int nBad = 0;

  // reference: bubbles still owed, and whether memory is being waited on
  int pend, pendN;
  bit waitM, waitMN;
  bit known;
  logic [1:0] eFA, eFB, eHS;
  logic eSF, eSD, eSE, eSM, eFD, eFE, eFW;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [REG_W-1:0] ra);
    if (RegWriteM && ra == WA3M && WA3M != PCR) return 2'b10;
    if (RegWriteW && ra == WA3W && WA3W != PCR) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model();
    bit mem, hit, pp, bt, hold;
    mem  = MemReqM && !MemReadyM;
    pp   = PCSrcD || PCSrcE || PCSrcM;
    bt   = BranchTakenE;
    hit  = MemtoRegE && RegWriteE && WA3E != PCR
           && (RA1D == WA3E || RA2D == WA3E);
    eHS  = waitM ? 2'b10 : (pend > 0 ? 2'b01 : 2'b00);
    eFA  = fwdRef(RA1E);
    eFB  = fwdRef(RA2E);
    {eSF, eSD, eSE, eSM, eFD, eFE, eFW} = '0;
    pendN  = pend;
    waitMN = 1'b0;
    if (reset) begin
      eFA = 2'b00; eFB = 2'b00;
      eFD = 1; eFE = 1; eFW = 1;
      pendN = 0;
    end else if (mem) begin
      {eSF, eSD, eSE, eSM, eFW} = '1;
      waitMN = 1'b1;
    end else begin
      hold = 0;
      if (waitM || pend > 0) begin
        if (bt) pendN = 0;
        else if (!waitM) begin hold = 1; pendN = pend - 1; end
      end else if (!bt && hit) begin
        hold = 1; pendN = LS - 1;
      end
      eSF = hold || pp;
      eSD = hold;
      eFE = hold || bt;
      eFD = (pp || PCSrcW || bt) && !hold;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model();
    chk("ForwardAE", 32'(ForwardAE), 32'(eFA));
    chk("ForwardBE", 32'(ForwardBE), 32'(eFB));
    chk("StallF", 32'(StallF), 32'(eSF));
    chk("StallD", 32'(StallD), 32'(eSD));
    chk("StallE", 32'(StallE), 32'(eSE));
    chk("StallM", 32'(StallM), 32'(eSM));
    chk("FlushD", 32'(FlushD), 32'(eFD));
    chk("FlushE", 32'(FlushE), 32'(eFE));
    chk("FlushW", 32'(FlushW), 32'(eFW));
    if (known) chk("HazState", 32'(HazState), 32'(eHS));
  endtask

  task automatic tick();
    @(posedge clk);
    pend  = pendN;
    waitM = waitMN;
    known = 1'b1;
    #1;
  endtask

  task automatic clearIn();
    RegWriteM = 0; RegWriteW = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RA1E = 0; RA2E = 0; RA1D = 0; RA2D = 0;
    MemtoRegE = 0; RegWriteE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic loadUse();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA1D = 4'd5;
  endtask

  initial begin
    int bub;
    pend = 0; waitM = 0; known = 0;
    clearIn();
    reset = 1;
    settle();
    chk("rst_FlushD", 32'(FlushD), 32'd1);
    chk("rst_FlushW", 32'(FlushW), 32'd1);
    chk("rst_StallF", 32'(StallF), 32'd0);
    tick();
    reset = 0;
    settle();
    chk("rst_HazState", 32'(HazState), 32'd0);
    tick();

    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
    settle(); chk("fwd_M", 32'(ForwardAE), 32'b10); tick();
    RegWriteM = 0;
    settle(); chk("fwd_W", 32'(ForwardAE), 32'b01); tick();
    RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15;
    settle(); chk("fwd_PC", 32'(ForwardAE), 32'b00); tick();
    clearIn();

    loadUse();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ld_StallF", 32'(StallF), 32'd1);
      chk("ld_FlushE", 32'(FlushE), 32'd1);
      chk("ld_HazState", 32'(HazState), (k == 0) ? 32'd0 : 32'd1);
      tick();
    end
    clearIn();
    settle();
    chk("ld_end_HazState", 32'(HazState), 32'd0);
    chk("ld_end_StallD", 32'(StallD), 32'd0);
    tick();

    MemReqM = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("mw_StallM", 32'(StallM), 32'd1);
      chk("mw_FlushW", 32'(FlushW), 32'd1);
      if (k > 0) chk("mw_HazState", 32'(HazState), 32'd2);
      tick();
    end
    MemReadyM = 1;
    settle();
    chk("mw_rdy_StallF", 32'(StallF), 32'd0);
    chk("mw_rdy_FlushW", 32'(FlushW), 32'd0);
    tick();
    clearIn();
    settle(); chk("mw_done_HazState", 32'(HazState), 32'd0); tick();

    bub = 0;
    loadUse();
    settle(); bub += int'(FlushE); tick();
    clearIn();
    MemReqM = 1;
    for (int k = 0; k < 2; k++) begin
      settle(); bub += int'(FlushE); tick();
    end
    MemReadyM = 1;
    settle(); bub += int'(FlushE); tick();
    clearIn();
    for (int k = 0; k < 4; k++) begin
      settle(); bub += int'(FlushE); tick();
    end
    chk("mwld_bubbles", 32'(bub), 32'd3);
    chk("mwld_HazState", 32'(HazState), 32'd0);

    loadUse();
    settle(); tick();
    clearIn();
    BranchTakenE = 1;
    settle();
    chk("br_StallF", 32'(StallF), 32'd0);
    chk("br_StallD", 32'(StallD), 32'd0);
    chk("br_FlushD", 32'(FlushD), 32'd1);
    chk("br_FlushE", 32'(FlushE), 32'd1);
    tick();
    clearIn();
    settle(); chk("br_HazState", 32'(HazState), 32'd0); tick();

    MemReqM = 1;
    settle(); tick();
    settle(); chk("rmw_HazState", 32'(HazState), 32'd2); tick();
    reset = 1;
    settle();
    chk("rmw_FlushE", 32'(FlushE), 32'd1);
    chk("rmw_StallM", 32'(StallM), 32'd0);
    tick();
    reset = 0;
    settle();
    chk("rmw_run", 32'(HazState), 32'd0);
    chk("rmw_StallE", 32'(StallE), 32'd1);
    tick();
    settle(); chk("rmw_again", 32'(HazState), 32'd2); tick();
    clearIn();

    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom);
      WA3E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      WA3M = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      WA3W = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      RA1D = 4'($urandom_range(0, 4)); RA2D = 4'($urandom_range(0, 4));
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemReqM = ($urandom_range(0, 3) == 0);
      MemReadyM = 1'($urandom);
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
